prv32_muldiv: RTL and testbench
===============================

# prv32_muldiv

Iterative RV32M multiply/divide unit for the pipelined RISC-V core, sitting in EX beside `prv32_ALU`. It accepts one operation at a time from the EX stage through a valid/ready handshake. It computes the result over a fixed number of cycles while the pipeline stalls, then returns the 32-bit result with a one-cycle valid pulse. It implements all eight M-extension operations, including the architected divide-by-zero and signed-overflow results.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: request valid.
- `in_ready` output 1: unit idle and able to accept.
- `op` input 3: operation, equal to funct3 (`MD_MUL`=0, `MD_MULH`=1, `MD_MULHSU`=2, `MD_MULHU`=3, `MD_DIV`=4, `MD_DIVU`=5, `MD_REM`=6, `MD_REMU`=7).
- `a` input 32: rs1 operand.
- `b` input 32: rs2 operand.
- `kill` input 1: synchronous flush from hazard/branch unit.
- `out_valid` output 1: result valid. Single-cycle pulse with no back-pressure.
- `result` output 32: result, held until the next accept.

## Operation
- States: IDLE, PREP, CALC, FIX.
- IDLE
  - `in_ready`=1.
  - On `in_valid & ~kill`: latch `op`, `a`, `b` → PREP.
- PREP
  - Record the result sign.
  - Take absolute values for signed operands: MULH both, MULHSU `a` only, DIV/REM both.
  - Load the 6-bit counter with 32 → CALC.
- CALC, one step per cycle:
  - Multiply: shift-add into a 64-bit product register.
  - Divide: restoring shift-subtract (remainder 33-bit, quotient 32-bit).
  - Counter decrements each step; → FIX when the counter hits 1.
- FIX
  - Apply sign correction and select the result:
    - MUL: low 32 bits of the product.
    - MULH/MULHSU/MULHU: high 32 bits of the product.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Register `result`, pulse `out_valid` → IDLE.
- Signed-result rules:
  - Quotient is negative when the operand signs differ.
  - Remainder takes the sign of `a`.
  - Product is negated when the signed-operand signs differ.
- Divide by zero (`b`=0):
  - Quotient = 0xFFFFFFFF for DIV and DIVU.
  - Remainder = `a`.
- Signed overflow (DIV/REM with `a`=0x80000000, `b`=0xFFFFFFFF): quotient 0x80000000, remainder 0.
- Special cases keep the normal latency; they are resolved in FIX.
- `kill` in any state:
  - Next state is IDLE.
  - No `out_valid`.
  - `result` is unchanged.
  - `kill` together with `in_valid` in IDLE: kill wins, nothing is accepted.
- Operands are only sampled on accept; changes on `a`/`b`/`op` while busy are ignored.

## Timing
- Accept edge T is the edge where `in_valid & in_ready & ~kill` is high.
- `out_valid` is high during the single cycle T+34:
  - 1 PREP cycle, then 32 CALC cycles, then the cycle after the last CALC step.
- `in_ready` is low from T+1 through T+34, and returns high at T+35.
- Back-to-back operations: next accept no earlier than T+35, a 35-cycle issue interval.
- Reset values (asynchronous when `rst`=0):
  - State IDLE.
  - `in_ready`=1, `out_valid`=0, `result`=0.
  - Counter and datapath registers are 0.
- Reset mid-operation aborts immediately. No `out_valid` follows release.
- After `kill` at edge K, `in_ready`=1 from K+1.

## Structure
- `defines.v`, shared with the ALU: `MD_*` funct3 constants, state encodings `MD_IDLE`/`MD_PREP`/`MD_CALC`/`MD_FIX`, and `MD_STEPS`=32.
- One sub-module, `prv32_muldiv_step`: combinational single iteration.
  - Inputs: mode, accumulator, operand.
  - Outputs: next accumulator and quotient/product bits.
  - Instantiated once in the CALC datapath.
- Top module holds the FSM, counter, sign bookkeeping and FIX mux.

## Test plan
- MUL `a`=7, `b`=6 → `result`=42, `out_valid` exactly at T+34; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULH `a`=-3, `b`=5 → 0xFFFFFFFF; MULHSU `a`=-1, `b`=0xFFFFFFFF → 0xFFFFFFFF.
- DIV `a`=-7, `b`=2 → -3; REM `a`=-7, `b`=2 → -1; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV/DIVU/REM by 0 with `a`=123 → 0xFFFFFFFF, 0xFFFFFFFF, 123; DIV 0x80000000/-1 → 0x80000000, REM → 0.
- `kill` at T+10 → no `out_valid` through T+40, `in_ready`=1 at T+11; `rst` low at T+20 → all outputs at reset values, no pulse after release.
- Back-to-back: second request held valid from T+1 → accepted at T+35, second `out_valid` at T+69, first `result` stable until then.

Source files
------------

// File: rtl/prv32_muldiv_pkg.sv
// rtl/prv32_muldiv_pkg.sv - shared constants, types and helpers for the RV32M multiply/divide unit
package prv32_muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_PREP = 2'd1;
    localparam logic [1:0] MD_CALC = 2'd2;
    localparam logic [1:0] MD_FIX  = 2'd3;

    localparam logic [5:0] MD_STEPS = 6'd32;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_e;

    // Magnitude of v when it is treated as signed (en=1), otherwise v unchanged.
    function automatic logic [XLEN-1:0] abs_if(input logic [XLEN-1:0] v, input logic en);
        return (en && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/prv32_muldiv_if.sv
// rtl/prv32_muldiv_if.sv - request/response bundle between the EX stage and the multiply/divide unit
interface prv32_muldiv_if;
    import prv32_muldiv_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            kill;
    logic            out_valid;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, op, a, b, kill,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, a, b, kill,
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/prv32_muldiv_step.sv
// rtl/prv32_muldiv_step.sv - one combinational shift-add or restoring shift-subtract iteration
module prv32_muldiv_step
    import prv32_muldiv_pkg::*;
(
    input  step_mode_e      mode,
    input  logic [64:0]     acc,
    input  logic [XLEN-1:0] operand,
    output logic [32:0]     hi_next,
    output logic [XLEN-1:0] bits_next
);

    logic [32:0] addend;
    logic [32:0] sum;
    logic [32:0] rem_sh;
    logic [33:0] diff;

    always_comb begin
        addend = acc[0] ? {1'b0, operand} : 33'd0;
        sum    = acc[64:32] + addend;
        rem_sh = {acc[63:32], acc[31]};
        diff   = {1'b0, rem_sh} - {2'b00, operand};
        if (mode == STEP_MUL) begin
            // Product register shifts right one bit per step; multiplier bits drain out of the low end.
            hi_next   = {1'b0, sum[32:1]};
            bits_next = {sum[0], acc[31:1]};
        end else begin
            hi_next   = diff[33] ? rem_sh : diff[32:0];
            bits_next = {acc[30:0], ~diff[33]};
        end
    end

endmodule

// File: rtl/prv32_muldiv.sv
// rtl/prv32_muldiv.sv - iterative RV32M multiply/divide unit: FSM, counter, sign bookkeeping and result mux
module prv32_muldiv
    import prv32_muldiv_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    prv32_muldiv_if.slave  bus
);

    logic [1:0]      state_q,   state_d;
    logic [2:0]      op_q,      op_d;
    logic [XLEN-1:0] a_q,       a_d;
    logic [XLEN-1:0] b_q,       b_d;
    logic [64:0]     acc_q,     acc_d;
    logic [5:0]      cnt_q,     cnt_d;
    logic            neg_q,     neg_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] result_q,  result_d;

    logic            sign_a;
    logic            sign_b;
    logic [32:0]     hi_next;
    logic [XLEN-1:0] bits_next;
    logic [63:0]     prod_fix;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] fix_result;
    logic            fix_fire;

    prv32_muldiv_step u_step (
        .mode      (step_mode_e'(op_q[2])),
        .acc       (acc_q),
        .operand   (b_q),
        .hi_next   (hi_next),
        .bits_next (bits_next)
    );

    always_comb begin
        sign_a = (op_q == MD_MULH) || (op_q == MD_MULHSU) || (op_q == MD_DIV) || (op_q == MD_REM);
        sign_b = (op_q == MD_MULH) || (op_q == MD_DIV) || (op_q == MD_REM);
    end

    // b_q holds |b| after PREP; it is zero exactly when the original b was zero.
    always_comb begin
        prod_fix = neg_q ? -acc_q[63:0] : acc_q[63:0];
        quo_fix  = neg_q ? -acc_q[31:0] : acc_q[31:0];
        rem_fix  = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];
        case (op_q)
            MD_MUL:                        fix_result = prod_fix[31:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  fix_result = prod_fix[63:32];
            MD_DIV, MD_DIVU:               fix_result = (b_q == '0) ? '1  : quo_fix;
            MD_REM, MD_REMU:               fix_result = (b_q == '0) ? a_q : rem_fix;
            default:                       fix_result = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        case (state_q)
            MD_IDLE: begin
                if (bus.in_valid && !bus.kill) begin
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    state_d = MD_PREP;
                end
            end
            MD_PREP: begin
                neg_d     = (sign_a & a_q[31]) ^ (sign_b & b_q[31]);
                neg_rem_d = sign_a & a_q[31];
                acc_d     = {33'd0, abs_if(a_q, sign_a)};
                b_d       = abs_if(b_q, sign_b);
                cnt_d     = MD_STEPS;
                state_d   = MD_CALC;
            end
            MD_CALC: begin
                acc_d = {hi_next, bits_next};
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                result_d = fix_result;
                state_d  = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
        if (bus.kill) begin
            state_d  = MD_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= MD_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    // The FIX cycle presents the freshly computed value; result_q captures it for holding afterwards.
    always_comb begin
        fix_fire      = (state_q == MD_FIX) && !bus.kill;
        bus.in_ready  = (state_q == MD_IDLE);
        bus.out_valid = fix_fire;
        bus.result    = fix_fire ? fix_result : result_q;
    end

endmodule

// File: tb/tb_prv32_muldiv.sv
// tb/tb_prv32_muldiv.sv - directed self-checking bench for prv32_muldiv
module tb_prv32_muldiv;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   vcnt;
    int   vcyc;
    int   vcyc2;
    int   bad;
    logic [31:0] res;
    logic [31:0] res2;
    logic        ir_a;
    logic        ir_b;

    prv32_muldiv_if bus ();

    prv32_muldiv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one operation from a negedge with the unit idle; watch 36 cycles after the accept edge.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        @(posedge clk);
        vcnt = 0; vcyc = 0; res = '0;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.in_valid = 1'b0;
                bus.a = $urandom; bus.b = $urandom; bus.op = 3'($urandom);
            end
            if (bus.out_valid) begin
                vcnt++;
                if (vcyc == 0) begin vcyc = c; res = bus.result; end
            end
        end
        check({tag, "_lat"}, 32'(vcyc), 32'd34);
        check({tag, "_pulses"}, 32'(vcnt), 32'd1);
        check({tag, "_result"}, res, exp);
        check({tag, "_held"}, bus.result, exp);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.kill = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", bus.result, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Back-to-back: second request held valid from T+1, accepted at T+35
        bus.op = 3'd0; bus.a = 32'd7; bus.b = 32'd6; bus.in_valid = 1'b1;
        @(posedge clk);
        vcyc = 0; vcyc2 = 0; res = '0; res2 = '0; bad = 0; vcnt = 0; ir_a = 1'b1; ir_b = 1'b0;
        for (int c = 1; c <= 72; c++) begin
            @(negedge clk);
            if (c == 1) begin bus.op = 3'd5; bus.a = 32'd100; bus.b = 32'd7; end
            if (bus.out_valid) begin
                vcnt++;
                if (c <= 40) begin vcyc = c; res = bus.result; end
                else begin vcyc2 = c; res2 = bus.result; end
            end
            if (c == 34) ir_a = bus.in_ready;
            if (c == 35) ir_b = bus.in_ready;
            if (c >= 35 && c <= 68 && bus.result !== 32'd42) bad++;
            if (c == 36) bus.in_valid = 1'b0;
        end
        check("b2b_first_lat", 32'(vcyc), 32'd34);
        check("b2b_first_res", res, 32'd42);
        check("b2b_ready_t34", 32'(ir_a), 32'd0);
        check("b2b_ready_t35", 32'(ir_b), 32'd1);
        check("b2b_hold_first", 32'(bad), 32'd0);
        check("b2b_second_lat", 32'(vcyc2), 32'd69);
        check("b2b_second_res", res2, 32'd14);
        check("b2b_pulses", 32'(vcnt), 32'd2);

        run_op(3'd0, 32'd7,        32'd6,        32'd42,       "mul_7x6");
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max");
        run_op(3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, "mulh_m3x5");
        run_op(3'd1, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, "mulh_m2xm3");
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1");
        run_op(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div_m7_2");
        run_op(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem_m7_2");
        run_op(3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, "div_7_m2");
        run_op(3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        "rem_7_m2");
        run_op(3'd5, 32'd100,      32'd7,        32'd14,       "divu_100_7");
        run_op(3'd7, 32'd100,      32'd7,        32'd2,        "remu_100_7");
        run_op(3'd4, 32'd123,      32'd0,        32'hFFFFFFFF, "div_by0");
        run_op(3'd5, 32'd123,      32'd0,        32'hFFFFFFFF, "divu_by0");
        run_op(3'd6, 32'd123,      32'd0,        32'd123,      "rem_by0");
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        "rem_ovf");
        run_op(3'd7, 32'd5,        32'd0,        32'd5,        "remu_by0");

        // Kill at T+10: no pulse through T+40, result keeps 5
        bus.op = 3'd5; bus.a = 32'd100; bus.b = 32'd7; bus.in_valid = 1'b1;
        @(posedge clk);
        vcnt = 0; ir_a = 1'b1; ir_b = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.out_valid) vcnt++;
            if (c == 1) bus.in_valid = 1'b0;
            if (c == 10) begin ir_a = bus.in_ready; bus.kill = 1'b1; end
            if (c == 11) begin ir_b = bus.in_ready; bus.kill = 1'b0; end
        end
        check("kill_ready_t10", 32'(ir_a), 32'd0);
        check("kill_ready_t11", 32'(ir_b), 32'd1);
        check("kill_no_pulse", 32'(vcnt), 32'd0);
        check("kill_result_kept", bus.result, 32'd5);

        // Kill together with in_valid while idle: nothing accepted
        bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd3; bus.in_valid = 1'b1; bus.kill = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.kill = 1'b0;
        check("kill_idle_ready", 32'(bus.in_ready), 32'd1);
        vcnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.out_valid) vcnt++;
        end
        check("kill_idle_no_pulse", 32'(vcnt), 32'd0);

        // Reset low at T+20 aborts the operation
        bus.op = 3'd0; bus.a = 32'd7; bus.b = 32'd6; bus.in_valid = 1'b1;
        @(posedge clk);
        vcnt = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 1) bus.in_valid = 1'b0;
            if (c == 20) begin
                rst = 1'b0;
                #1;
                check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
                check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
                check("midrst_result", bus.result, 32'd0);
            end
            if (c == 22) rst = 1'b1;
            if (bus.out_valid) vcnt++;
        end
        check("midrst_no_pulse", 32'(vcnt), 32'd0);
        check("midrst_result_after", bus.result, 32'd0);

        run_op(3'd0, 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, "mul_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
